// File: rtl/fredkin_univ_shift_reg_if.sv
// Bus bundle for the Fredkin universal shift register: mode/serial/parallel inputs
// and the register contents with their complement and serial outputs.
interface fredkin_univ_shift_reg_if #(
  parameter int unsigned WIDTH = 4
);
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             sout_r;
  logic             sout_l;

  // Driver side (stimulus / enclosing logic).
  modport master (
    output mode, sin_r, sin_l, d,
    input  q, qb, sout_r, sout_l
  );

  // Register side.
  modport slave (
    input  mode, sin_r, sin_l, d,
    output q, qb, sout_r, sout_l
  );
endinterface

// File: rtl/fredkin_univ_shift_reg.sv
// WIDTH-bit universal shift register whose next-state selection is built entirely from
// Fredkin (controlled-swap) gates: per bit, an 8:1 tree of seven gates steered by mode,
// plus one gate wired as an inverter that supplies both the complement candidate and qb.
module fredkin_univ_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  fredkin_univ_shift_reg_if.slave sr_io
);

  if (WIDTH < 2 || WIDTH > 32) begin : gen_bad_width
    $error("fredkin_univ_shift_reg: WIDTH must be in 2..32");
  end

  // Fredkin gate {c, x, y}: c passes through, a/b are swapped when c is 1.
  // Used as a mux, x = c ? b : a; with a=1, b=0 it inverts c.
  function automatic logic [2:0] fredkin(input logic c, input logic a, input logic b);
    return {c, (c ? b : a), (c ? a : b)};
  endfunction

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] qb_w;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    logic       nbr_r;  // bit arriving from the left on shift right
    logic       nbr_l;  // bit arriving from the right on shift left
    logic       rot_r;
    logic       rot_l;
    logic [2:0] g_inv;
    logic [2:0] g0, g1, g2, g3, g4, g5, g6;
    logic       unused_garbage;

    if (i == WIDTH - 1) begin : gen_msb
      assign nbr_r = sr_io.sin_r;
      assign rot_r = q_q[0];
    end else begin : gen_mid_r
      assign nbr_r = q_q[i+1];
      assign rot_r = q_q[i+1];
    end

    if (i == 0) begin : gen_lsb
      assign nbr_l = sr_io.sin_l;
      assign rot_l = q_q[WIDTH-1];
    end else begin : gen_mid_l
      assign nbr_l = q_q[i-1];
      assign rot_l = q_q[i-1];
    end

    // Inverter from the stored bit: feeds the complement path and qb.
    assign g_inv = fredkin(q_q[i], 1'b1, 1'b0);

    // Level 0 (mode[0]): pairs 000/001, 010/011, 100/101, 110/111.
    assign g0 = fredkin(sr_io.mode[0], q_q[i], nbr_r);
    assign g1 = fredkin(sr_io.mode[0], nbr_l, sr_io.d[i]);
    assign g2 = fredkin(sr_io.mode[0], rot_r, rot_l);
    assign g3 = fredkin(sr_io.mode[0], 1'b0, g_inv[1]);
    // Level 1 (mode[1]) and level 2 (mode[2]).
    assign g4 = fredkin(sr_io.mode[1], g0[1], g1[1]);
    assign g5 = fredkin(sr_io.mode[1], g2[1], g3[1]);
    assign g6 = fredkin(sr_io.mode[2], g4[1], g5[1]);

    assign q_d[i]  = g6[1];
    assign qb_w[i] = g_inv[1];

    // Garbage outputs are collected here only so they are visibly discarded.
    assign unused_garbage = ^{g_inv[2], g_inv[0], g0[2], g0[0], g1[2], g1[0], g2[2], g2[0],
                              g3[2], g3[0], g4[2], g4[0], g5[2], g5[0], g6[2], g6[0]};
  end

  // Storage: positive-edge cells, asynchronously cleared; reset drops any pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign sr_io.q      = q_q;
  assign sr_io.qb     = qb_w;
  assign sr_io.sout_r = q_q[0];
  assign sr_io.sout_l = q_q[WIDTH-1];

endmodule
